// File: rtl/spi_host_tx_fifo.sv
// rtl/spi_host_tx_fifo.sv - SPI host TX FIFO: 36-bit entries, FWFT read, drop-on-full with overflow pulse
module spi_host_tx_fifo #(
    parameter  int Depth = 72,
    localparam int CW    = $clog2(Depth + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          wr_valid_i,
    input  logic [31:0]   wr_data_i,
    input  logic [3:0]    wr_be_i,
    input  logic          clr_i,
    output logic          rd_valid_o,
    output logic [31:0]   rd_data_o,
    output logic [3:0]    rd_be_o,
    input  logic          rd_ready_i,
    output logic [CW-1:0] depth_o,
    output logic          full_o,
    output logic          empty_o,
    input  logic [CW-1:0] wm_i,
    output logic          wm_o,
    output logic          overflow_o
);

    localparam int            PW       = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [PW-1:0] LAST_PTR = PW'(Depth - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(Depth);

    logic [35:0]   r_mem [Depth];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          r_overflow;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_drop;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == FULL_CNT);
    // A pop frees the slot the same-cycle push lands in, so a full FIFO still accepts it
    assign w_pop   = ~w_empty & rd_ready_i;
    assign w_push  = wr_valid_i & (~w_full | w_pop);
    assign w_drop  = wr_valid_i & w_full & ~w_pop;

    // Storage write; contents are intentionally never reset or cleared
    always_ff @(posedge clk_i) begin
        if (w_push && !clr_i) begin
            r_mem[r_wptr] <= {wr_be_i, wr_data_i};
        end
    end

    // Pointers, occupancy and overflow pulse; flush overrides any push or pop
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (clr_i) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= w_drop;
            if (w_push) begin
                r_wptr <= (r_wptr == LAST_PTR) ? '0 : r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == LAST_PTR) ? '0 : r_rptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign rd_valid_o = ~w_empty;
    assign rd_data_o  = r_mem[r_rptr][31:0];
    assign rd_be_o    = r_mem[r_rptr][35:32];
    assign depth_o    = r_count;
    assign full_o     = w_full;
    assign empty_o    = w_empty;
    assign wm_o       = (r_count < wm_i);
    assign overflow_o = r_overflow;

endmodule

// File: doc/spi_host_tx_fifo.md
SPI_HOST_TX_FIFO -- requirements
Module: spi_host_tx_fifo

Interface
REQ-001 Parameter Depth, default 72: number of 36-bit entries (32 data bits plus 4 byte-enable bits); any integer from 2 to 256, not required to be a power of two.
REQ-002 Derived width CW = $clog2(Depth+1): width of the occupancy and watermark fields.
REQ-003 clk_i  in  1  sole clock; every register samples on its rising edge.
REQ-004 rst_i  in  1  asynchronous active-high reset.
REQ-005 wr_valid_i  in  1  push request from the TX data window, one word per cycle.
REQ-006 wr_data_i  in  32  push data word.
REQ-007 wr_be_i  in  4  push byte enables; bit n qualifies wr_data_i[8n+7:8n].
REQ-008 clr_i  in  1  synchronous flush request (software TX reset).
REQ-009 rd_valid_o  out  1  head entry available to the shift engine.
REQ-010 rd_data_o  out  32  head data word.
REQ-011 rd_be_o  out  4  head byte enables.
REQ-012 rd_ready_i  in  1  shift engine consumes the head entry.
REQ-013 depth_o  out  CW  current occupancy.
REQ-014 full_o  out  1  occupancy equals Depth.
REQ-015 empty_o  out  1  occupancy equals 0.
REQ-016 wm_i  in  CW  TX watermark threshold.
REQ-017 wm_o  out  1  occupancy strictly below wm_i.
REQ-018 overflow_o  out  1  one-cycle pulse when a push is dropped.

Function
REQ-019 The block has no push backpressure; the upstream window is always ready, so a dropped push is reported only through overflow_o.
REQ-020 Push: when wr_valid_i=1 and the push is accepted, {wr_be_i, wr_data_i} is written at wptr and wptr advances by 1.
REQ-021 Push acceptance: a push is accepted when occupancy < Depth, or when occupancy = Depth and a pop occurs in the same cycle.
REQ-022 Dropped push: wr_valid_i=1 with occupancy = Depth and no same-cycle pop leaves storage and pointers unchanged, and overflow_o=1 on the next cycle for exactly one cycle.
REQ-023 Pop: pop occurs when rd_valid_o=1 and rd_ready_i=1; rptr advances by 1.
REQ-024 rd_ready_i while empty has no effect.
REQ-025 Read path is first-word fall-through: rd_valid_o = ~empty_o, and rd_data_o/rd_be_o show the entry at rptr combinationally.
REQ-026 There is no empty bypass: a word pushed into an empty FIFO appears on rd_valid_o one cycle after the push.
REQ-027 Pointer wrap: wptr and rptr each advance Depth-1 -> 0 and are otherwise +1.
REQ-028 Occupancy is held in a CW-bit counter: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop or when idle; it never exceeds Depth and never underflows.
REQ-029 full_o, empty_o, depth_o and wm_o are derived from the registered counter, so they update in the cycle after the event.
REQ-030 wm_o is the unsigned compare (depth_o < wm_i); wm_i=0 forces wm_o=0.
REQ-031 Flush: clr_i=1 zeroes wptr, rptr and the counter on the next edge and takes priority over any same-cycle push or pop.
REQ-032 A push or pop coincident with clr_i is discarded and does not raise overflow_o.
REQ-033 Storage contents are not reset or cleared; only pointers, counter and overflow_o are reset.
REQ-034 Byte enables are stored verbatim: all-zero, sparse and non-contiguous patterns are preserved unchanged.

Reset
REQ-035 While rst_i=1: pointers=0, counter=0, rd_valid_o=0, empty_o=1, full_o=0, depth_o=0, overflow_o=0, and wm_o=(0<wm_i).
REQ-036 Assertion of rst_i mid-operation discards all queued entries immediately (asynchronously).
REQ-037 The first push is accepted on the first rising edge after rst_i deasserts.

Verification
REQ-038 Reset; push 0xA5A5_0001/be 0xF -> cycle+1: rd_valid_o=1, rd_data_o=0xA5A5_0001, depth_o=1; pop -> cycle+1: empty_o=1.
REQ-039 Depth=4; push 5 words with no pops -> after 4: full_o=1, depth_o=4; the 5th push gives overflow_o=1 for one cycle and the head remains word 1.
REQ-040 Depth=4 full; push and pop in the same cycle -> depth_o stays 4, overflow_o=0, and pop order continues word 2 through word 5.
REQ-041 Depth=3; 10 push/pop pairs with be cycling 0x1, 0x6, 0x8, 0x0 -> output data and be match input order exactly across pointer wrap.
REQ-042 wm_i=2; occupancy steps 0 -> 1 -> 2 -> 1 -> wm_o reads 1, 1, 0, 1.
REQ-043 3 words queued; clr_i together with push and pop -> next cycle: depth_o=0, empty_o=1, overflow_o=0; rst_i pulsed mid-stream -> empty immediately.
